rv_conv_mac_unit: RTL and testbench

Parametrised multi-lane multiply-accumulate unit for the execute stage. Each beat forms a per-thread dot product of rs1 × rs2 over active threads (tmask), then reduces it in an adder tree. The result is optionally folded into a per-warp accumulator, and the value is returned to all active threads through the commit interface. It replaces the fixed 32-bit single-accumulator convolution unit with:
- configurable lane count, accumulator width and saturation;
- signed and unsigned modes;
- per-warp accumulator state;
- a fully stallable 3-stage pipeline.

---
 rtl/rv_conv_mac_unit_pkg.sv | 28 ++
 rtl/rv_conv_adder_tree.sv | 28 ++
 rtl/rv_conv_mac_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_rv_conv_mac_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_conv_mac_unit_pkg.sv
// Shared definitions for the convolution multiply-accumulate unit.
// Holds the core-wide sizing constants, the op encodings and the
// instruction tag that travels alongside every beat in the pipeline.
package rv_conv_mac_unit_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int UUID_BITS   = 44;
  localparam int NR_BITS     = 5;

  typedef enum logic [1:0] {
    CONV_OP_DOT      = 2'b00,
    CONV_OP_ACC_INIT = 2'b01,
    CONV_OP_ACC      = 2'b10,
    CONV_OP_ACC_READ = 2'b11
  } conv_op_e;

  // Instruction tag carried unchanged from request to commit.
  typedef struct packed {
    logic [UUID_BITS-1:0] uuid;
    logic [NW_BITS-1:0]   wid;
    logic [31:0]          pc;
    logic [NR_BITS-1:0]   rd;
    logic                 wb;
  } conv_tag_t;

endpackage

// File: rtl/rv_conv_adder_tree.sv
// Combinational binary reduction of N equal-width operands.
// Ports:
//   data : N operands packed, operand i at data[i*DATAW +: DATAW]
//   sum  : modular sum of all operands, DATAW bits
// Nodes are laid out as a 1-based heap: leaves at N..2N-1, each inner
// node i adds its children 2i and 2i+1, root at node 1. N must be a
// power of two, giving log2(N) adder levels.
module rv_conv_adder_tree #(
  parameter int N     = 4,
  parameter int DATAW = 34
) (
  input  logic [N*DATAW-1:0] data,
  output logic [DATAW-1:0]   sum
);

  always_comb begin : reduce
    logic [DATAW-1:0] node [2*N];
    node[0] = '0;
    for (int i = 0; i < N; i++) begin
      node[N+i] = data[i*DATAW +: DATAW];
    end
    for (int i = N - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i+1];
    end
    sum = node[1];
  end

endmodule

// File: rtl/rv_conv_mac_unit.sv
// Multi-lane multiply-accumulate unit for the execute stage.
// S1 multiplies rs1*rs2 per active lane, S2 reduces the lane products in
// an adder tree, S3 applies the op against the per-warp accumulator and
// registers the result, replicated to every lane of the commit data.
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   conv_req_if_*               : request handshake, tag, op, mode, operands
//   conv_commit_if_*            : commit handshake, tag, result data, eop
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high. The producer holds valid and payload until the transfer;
// ready never depends on valid in the same cycle. Here the request side is
// ready whenever the commit register is not holding an unaccepted beat,
// and that single stall condition freezes all three stages together.
module rv_conv_mac_unit
  import rv_conv_mac_unit_pkg::*;
#(
  parameter int CORE_ID   = 0,
  parameter int NUM_LANES = NUM_THREADS,
  parameter int ACCW      = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   conv_req_if_valid,
  output logic                   conv_req_if_ready,
  input  logic [UUID_BITS-1:0]   conv_req_if_uuid,
  input  logic [NW_BITS-1:0]     conv_req_if_wid,
  input  logic [NUM_LANES-1:0]   conv_req_if_tmask,
  input  logic [31:0]            conv_req_if_PC,
  input  logic [NR_BITS-1:0]     conv_req_if_rd,
  input  logic                   conv_req_if_wb,
  input  logic [1:0]             conv_req_if_op,
  input  logic                   conv_req_if_unsigned,
  input  logic [NUM_LANES*32-1:0] conv_req_if_rs1_data,
  input  logic [NUM_LANES*32-1:0] conv_req_if_rs2_data,
  output logic                   conv_commit_if_valid,
  input  logic                   conv_commit_if_ready,
  output logic [UUID_BITS-1:0]   conv_commit_if_uuid,
  output logic [NW_BITS-1:0]     conv_commit_if_wid,
  output logic [NUM_LANES-1:0]   conv_commit_if_tmask,
  output logic [31:0]            conv_commit_if_PC,
  output logic [NR_BITS-1:0]     conv_commit_if_rd,
  output logic                   conv_commit_if_wb,
  output logic [NUM_LANES*32-1:0] conv_commit_if_data,
  output logic                   conv_commit_if_eop
);

  localparam int LOGN = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
  localparam int SW   = ACCW + LOGN;  // tree width, cannot overflow
  localparam int EW   = SW + 1;       // headroom for acc + sum

  if (ACCW < 32 || ACCW > 64 || NUM_LANES < 1 ||
      (NUM_LANES & (NUM_LANES - 1)) != 0 || CORE_ID < 0) begin : g_bad_params
    $error("rv_conv_mac_unit: illegal parameter set");
  end

  logic stall, advance;
  assign stall             = conv_commit_if_valid & ~conv_commit_if_ready;
  assign advance           = ~stall;
  assign conv_req_if_ready = advance;
  assign conv_commit_if_eop = 1'b1;

  // ---------------- S1: per-lane multiply ----------------
  // Only the low ACCW product bits are kept, and those bits are the same
  // whether formed from a full 64-bit product or an ACCW-bit one.
  logic [NUM_LANES*ACCW-1:0] prod_d;
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      logic [31:0]     a, b;
      logic [ACCW-1:0] ax, bx;
      a = conv_req_if_rs1_data[i*32 +: 32];
      b = conv_req_if_rs2_data[i*32 +: 32];
      if (conv_req_if_unsigned) begin
        ax = ACCW'(a);
        bx = ACCW'(b);
      end else begin
        ax = ACCW'($signed(a));
        bx = ACCW'($signed(b));
      end
      if (conv_req_if_tmask[i]) prod_d[i*ACCW +: ACCW] = ax * bx;
    end
  end

  logic                      s1_valid, s1_uns;
  conv_tag_t                 s1_tag;
  logic [NUM_LANES-1:0]      s1_tmask;
  conv_op_e                  s1_op;
  logic [NUM_LANES*ACCW-1:0] s1_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_uns   <= 1'b0;
      s1_tag   <= '0;
      s1_tmask <= '0;
      s1_op    <= CONV_OP_DOT;
      s1_prod  <= '0;
    end else if (advance) begin
      s1_valid <= conv_req_if_valid;
      s1_uns   <= conv_req_if_unsigned;
      s1_tag   <= '{uuid: conv_req_if_uuid, wid: conv_req_if_wid, pc: conv_req_if_PC,
                    rd: conv_req_if_rd, wb: conv_req_if_wb};
      s1_tmask <= conv_req_if_tmask;
      s1_op    <= conv_op_e'(conv_req_if_op);
      s1_prod  <= prod_d;
    end
  end

  // ---------------- S2: reduce ----------------
  logic [NUM_LANES*SW-1:0] tree_in;
  logic [SW-1:0]           tree_sum;
  always_comb begin
    tree_in = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      logic [ACCW-1:0] p;
      p = s1_prod[i*ACCW +: ACCW];
      if (s1_uns) tree_in[i*SW +: SW] = SW'(p);
      else        tree_in[i*SW +: SW] = SW'($signed(p));
    end
  end

  rv_conv_adder_tree #(.N(NUM_LANES), .DATAW(SW)) u_tree (
    .data (tree_in),
    .sum  (tree_sum)
  );

  logic                 s2_valid, s2_uns;
  conv_tag_t            s2_tag;
  logic [NUM_LANES-1:0] s2_tmask;
  conv_op_e             s2_op;
  logic [SW-1:0]        s2_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_uns   <= 1'b0;
      s2_tag   <= '0;
      s2_tmask <= '0;
      s2_op    <= CONV_OP_DOT;
      s2_sum   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_uns   <= s1_uns;
      s2_tag   <= s1_tag;
      s2_tmask <= s1_tmask;
      s2_op    <= s1_op;
      s2_sum   <= tree_sum;
    end
  end

  // ---------------- S3: accumulate / output ----------------
  // Reduce an EW-bit value to ACCW bits: clamp to the signed or unsigned
  // range when saturating, otherwise keep the low bits (wrap).
  function automatic logic [ACCW-1:0] fit(input logic [EW-1:0] v, input logic uns);
    logic [ACCW-1:0] r;
    r = v[ACCW-1:0];
    if (SATURATE) begin
      if (uns) begin
        if (v[EW-1:ACCW] != '0) r = '1;
      end else if (v[EW-1:ACCW-1] != {(EW-ACCW+1){v[EW-1]}}) begin
        r = v[EW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      end
    end
    return r;
  endfunction

  logic [ACCW-1:0] acc_q [NUM_WARPS];
  logic [ACCW-1:0] acc_cur, res_d, acc_d;
  logic [EW-1:0]   sum_x, acc_x;
  logic            acc_we;

  always_comb begin
    acc_cur = acc_q[s2_tag.wid];
    if (s2_uns) begin
      sum_x = EW'(s2_sum);
      acc_x = EW'(acc_cur);
    end else begin
      sum_x = EW'($signed(s2_sum));
      acc_x = EW'($signed(acc_cur));
    end
    res_d  = '0;
    acc_d  = '0;
    acc_we = 1'b0;
    case (s2_op)
      CONV_OP_DOT: res_d = fit(sum_x, s2_uns);
      CONV_OP_ACC_INIT: begin
        res_d  = fit(sum_x, s2_uns);
        acc_d  = res_d;
        acc_we = 1'b1;
      end
      CONV_OP_ACC: begin
        res_d  = fit(acc_x + sum_x, s2_uns);
        acc_d  = res_d;
        acc_we = 1'b1;
      end
      CONV_OP_ACC_READ: begin
        res_d  = acc_cur;
        acc_we = 1'b1;  // read clears the accumulator
      end
      default: res_d = '0;
    endcase
  end

  conv_tag_t s3_tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_commit_if_valid <= 1'b0;
      s3_tag               <= '0;
      conv_commit_if_tmask <= '0;
      conv_commit_if_data  <= '0;
      for (int w = 0; w < NUM_WARPS; w++) acc_q[w] <= '0;
    end else if (advance) begin
      conv_commit_if_valid <= s2_valid;
      s3_tag               <= s2_tag;
      conv_commit_if_tmask <= s2_tmask;
      conv_commit_if_data  <= {NUM_LANES{res_d[31:0]}};
      if (s2_valid && acc_we) acc_q[s2_tag.wid] <= acc_d;
    end
  end

  assign conv_commit_if_uuid = s3_tag.uuid;
  assign conv_commit_if_wid  = s3_tag.wid;
  assign conv_commit_if_PC   = s3_tag.pc;
  assign conv_commit_if_rd   = s3_tag.rd;
  assign conv_commit_if_wb   = s3_tag.wb;

endmodule

// File: tb/tb_rv_conv_mac_unit.sv
// Directed bench for rv_conv_mac_unit: a wrapping instance (u_dut) and a
// saturating instance (u_sat), both with four lanes and ACCW=32.
module tb_rv_conv_mac_unit;
  import rv_conv_mac_unit_pkg::*;

  localparam int NL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // shared request payload
  logic [UUID_BITS-1:0] req_uuid;
  logic [NW_BITS-1:0]   req_wid;
  logic [NL-1:0]        req_tmask;
  logic [31:0]          req_pc;
  logic [NR_BITS-1:0]   req_rd;
  logic                 req_wb;
  logic [1:0]           req_op;
  logic                 req_uns;
  logic [NL*32-1:0]     req_rs1, req_rs2;

  logic                 d_req_valid, d_req_ready, d_cm_valid, d_cm_ready, d_cm_wb, d_cm_eop;
  logic [UUID_BITS-1:0] d_cm_uuid;
  logic [NW_BITS-1:0]   d_cm_wid;
  logic [NL-1:0]        d_cm_tmask;
  logic [31:0]          d_cm_pc;
  logic [NR_BITS-1:0]   d_cm_rd;
  logic [NL*32-1:0]     d_cm_data;

  logic                 s_req_valid, s_req_ready, s_cm_valid, s_cm_ready, s_cm_wb, s_cm_eop;
  logic [UUID_BITS-1:0] s_cm_uuid;
  logic [NW_BITS-1:0]   s_cm_wid;
  logic [NL-1:0]        s_cm_tmask;
  logic [31:0]          s_cm_pc;
  logic [NR_BITS-1:0]   s_cm_rd;
  logic [NL*32-1:0]     s_cm_data;

  rv_conv_mac_unit #(.CORE_ID(0), .NUM_LANES(NL), .ACCW(32), .SATURATE(1'b0)) u_dut (
    .clk(clk), .reset(reset),
    .conv_req_if_valid(d_req_valid), .conv_req_if_ready(d_req_ready),
    .conv_req_if_uuid(req_uuid), .conv_req_if_wid(req_wid), .conv_req_if_tmask(req_tmask),
    .conv_req_if_PC(req_pc), .conv_req_if_rd(req_rd), .conv_req_if_wb(req_wb),
    .conv_req_if_op(req_op), .conv_req_if_unsigned(req_uns),
    .conv_req_if_rs1_data(req_rs1), .conv_req_if_rs2_data(req_rs2),
    .conv_commit_if_valid(d_cm_valid), .conv_commit_if_ready(d_cm_ready),
    .conv_commit_if_uuid(d_cm_uuid), .conv_commit_if_wid(d_cm_wid), .conv_commit_if_tmask(d_cm_tmask),
    .conv_commit_if_PC(d_cm_pc), .conv_commit_if_rd(d_cm_rd), .conv_commit_if_wb(d_cm_wb),
    .conv_commit_if_data(d_cm_data), .conv_commit_if_eop(d_cm_eop)
  );

  rv_conv_mac_unit #(.CORE_ID(1), .NUM_LANES(NL), .ACCW(32), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset),
    .conv_req_if_valid(s_req_valid), .conv_req_if_ready(s_req_ready),
    .conv_req_if_uuid(req_uuid), .conv_req_if_wid(req_wid), .conv_req_if_tmask(req_tmask),
    .conv_req_if_PC(req_pc), .conv_req_if_rd(req_rd), .conv_req_if_wb(req_wb),
    .conv_req_if_op(req_op), .conv_req_if_unsigned(req_uns),
    .conv_req_if_rs1_data(req_rs1), .conv_req_if_rs2_data(req_rs2),
    .conv_commit_if_valid(s_cm_valid), .conv_commit_if_ready(s_cm_ready),
    .conv_commit_if_uuid(s_cm_uuid), .conv_commit_if_wid(s_cm_wid), .conv_commit_if_tmask(s_cm_tmask),
    .conv_commit_if_PC(s_cm_pc), .conv_commit_if_rd(s_cm_rd), .conv_commit_if_wb(s_cm_wb),
    .conv_commit_if_data(s_cm_data), .conv_commit_if_eop(s_cm_eop)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0]      exp_q[$];
  logic [NL*32-1:0] got_d[$];
  logic [NL*32-1:0] got_s[$];
  logic [UUID_BITS-1:0] uuid_ctr = '0;

  // A commit seen valid&ready at the falling edge transfers on the next rising edge.
  always @(negedge clk) begin
    if (reset && d_cm_valid && d_cm_ready) got_d.push_back(d_cm_data);
    if (reset && s_cm_valid && s_cm_ready) got_s.push_back(s_cm_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NL*32-1:0] lanes(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic idle();
    d_req_valid = 1'b0;
    s_req_valid = 1'b0;
  endtask

  // Presents one beat and returns #1 after the edge on which it was accepted.
  task automatic drive_beat(input logic [1:0] op, input logic [NW_BITS-1:0] wid,
                            input logic [NL-1:0] tm, input logic uns,
                            input logic [NL*32-1:0] a, input logic [NL*32-1:0] b,
                            input bit sat);
    logic rdy;
    req_op = op; req_wid = wid; req_tmask = tm; req_uns = uns;
    req_rs1 = a; req_rs2 = b;
    req_uuid = uuid_ctr;
    req_pc = 32'h1000 + {uuid_ctr[29:0], 2'b00};
    req_rd = uuid_ctr[4:0];
    req_wb = 1'b1;
    uuid_ctr++;
    if (sat) s_req_valid = 1'b1; else d_req_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = sat ? s_req_ready : d_req_ready;
      @(posedge clk); #1;
      if (rdy) return;
    end
    checks++; errors++;
    $display("FAIL drive_timeout uuid=%0d never accepted, ready required", req_uuid);
  endtask

  task automatic wait_got(input int n, input bit sat, output bit to);
    to = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ((sat ? got_s.size() : got_d.size()) >= n) begin
        to = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; idle();
    d_cm_ready = 1'b1; s_cm_ready = 1'b1;
    req_uuid = '0; req_wid = '0; req_tmask = '0; req_pc = '0; req_rd = '0; req_wb = 1'b0;
    req_op = 2'b00; req_uns = 1'b0; req_rs1 = '0; req_rs2 = '0;
    #1;
    checks++; if (d_cm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", d_cm_valid); end
    checks++; if (d_cm_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", d_cm_data); end
    checks++; if (d_cm_uuid !== '0 || d_cm_pc !== '0) begin errors++; $display("FAIL reset_tag uuid=%h pc=%h exp=0", d_cm_uuid, d_cm_pc); end
    checks++; if (s_cm_valid !== 1'b0) begin errors++; $display("FAIL reset_sat_valid got=%b exp=0", s_cm_valid); end
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", d_req_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (d_cm_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", d_cm_valid); end
  endtask

  task automatic test_dot_latency();
    logic [UUID_BITS-1:0] sent_uuid;
    logic [31:0] sent_pc;
    got_d.delete();
    drive_beat(2'b00, 2'd3, 4'b1111, 1'b0, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b0);
    sent_uuid = req_uuid; sent_pc = req_pc;
    idle();
    @(negedge clk);
    checks++; if (d_cm_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1 valid got=%b exp=0", d_cm_valid); end
    @(negedge clk);
    checks++; if (d_cm_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle2 valid got=%b exp=0", d_cm_valid); end
    @(negedge clk);
    checks++; if (d_cm_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle3 valid got=%b exp=1", d_cm_valid); end
    checks++; if (d_cm_data !== {4{32'd70}}) begin errors++; $display("FAIL dot_data got=%h exp=%h", d_cm_data, {4{32'd70}}); end
    checks++; if (d_cm_uuid !== sent_uuid || d_cm_pc !== sent_pc || d_cm_wid !== 2'd3)
      begin errors++; $display("FAIL dot_tag uuid=%h pc=%h wid=%0d exp uuid=%h pc=%h wid=3", d_cm_uuid, d_cm_pc, d_cm_wid, sent_uuid, sent_pc); end
    checks++; if (d_cm_tmask !== 4'b1111 || d_cm_rd !== sent_uuid[4:0] || d_cm_wb !== 1'b1 || d_cm_eop !== 1'b1)
      begin errors++; $display("FAIL dot_tag2 tmask=%b rd=%0d wb=%b eop=%b", d_cm_tmask, d_cm_rd, d_cm_wb, d_cm_eop); end
    @(posedge clk); #1;
    got_d.delete();
  endtask

  task automatic test_tmask_sign();
    bit to;
    got_d.delete(); exp_q.delete();
    drive_beat(2'b00, 2'd0, 4'b0101, 1'b0, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b0);
    exp_q.push_back(32'd26);
    drive_beat(2'b00, 2'd0, 4'b1111, 1'b0, lanes(32'hFFFFFFFD, 0, 0, 0), lanes(7, 0, 0, 0), 1'b0);
    exp_q.push_back(32'hFFFFFFEB);
    drive_beat(2'b00, 2'd0, 4'b1111, 1'b1, lanes(32'hFFFFFFFD, 0, 0, 0), lanes(7, 0, 0, 0), 1'b0);
    exp_q.push_back(32'hFFFFFFEB);
    drive_beat(2'b00, 2'd1, 4'b0000, 1'b0, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b0);
    exp_q.push_back(32'd0);
    drive_beat(2'b00, 2'd1, 4'b1000, 1'b0, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b0);
    exp_q.push_back(32'd32);
    idle();
    wait_got(5, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL tmask_timeout got=%0d commits exp=5", got_d.size()); end
    while (exp_q.size() > 0 && got_d.size() > 0) begin
      logic [31:0] e;
      logic [NL*32-1:0] g;
      e = exp_q.pop_front(); g = got_d.pop_front();
      checks++; if (g !== {4{e}}) begin errors++; $display("FAIL tmask_sign_data got=%h exp=%h", g, {4{e}}); end
    end
  endtask

  task automatic test_acc_sequence();
    bit to;
    logic [NL*32-1:0] ones;
    ones = lanes(1, 1, 1, 1);
    got_d.delete(); exp_q.delete();
    drive_beat(2'b01, 2'd1, 4'b1111, 1'b0, lanes(100, 0, 0, 0), ones, 1'b0); exp_q.push_back(32'd100);
    drive_beat(2'b01, 2'd2, 4'b1111, 1'b0, lanes(1, 2, 3, 4), ones, 1'b0);   exp_q.push_back(32'd10);
    drive_beat(2'b10, 2'd2, 4'b1111, 1'b0, lanes(5, 0, 0, 0), ones, 1'b0);   exp_q.push_back(32'd15);
    drive_beat(2'b10, 2'd2, 4'b1111, 1'b0, lanes(7, 0, 0, 0), ones, 1'b0);   exp_q.push_back(32'd22);
    drive_beat(2'b00, 2'd2, 4'b1111, 1'b0, lanes(3, 0, 0, 0), ones, 1'b0);   exp_q.push_back(32'd3);
    drive_beat(2'b11, 2'd2, 4'b1111, 1'b0, lanes(9, 9, 9, 9), ones, 1'b0);   exp_q.push_back(32'd22);
    drive_beat(2'b11, 2'd2, 4'b1111, 1'b0, '0, '0, 1'b0);                    exp_q.push_back(32'd0);
    drive_beat(2'b11, 2'd1, 4'b1111, 1'b0, '0, '0, 1'b0);                    exp_q.push_back(32'd100);
    drive_beat(2'b11, 2'd1, 4'b1111, 1'b0, '0, '0, 1'b0);                    exp_q.push_back(32'd0);
    idle();
    wait_got(9, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL acc_timeout got=%0d commits exp=9", got_d.size()); end
    while (exp_q.size() > 0 && got_d.size() > 0) begin
      logic [31:0] e;
      logic [NL*32-1:0] g;
      e = exp_q.pop_front(); g = got_d.pop_front();
      checks++; if (g !== {4{e}}) begin errors++; $display("FAIL acc_seq_data got=%h exp=%h", g, {4{e}}); end
    end
  endtask

  task automatic test_saturate();
    bit to;
    logic [NL*32-1:0] one0, two1;
    one0 = lanes(1, 0, 0, 0);
    two1 = lanes(1, 1, 0, 0);
    got_s.delete(); got_d.delete(); exp_q.delete();
    drive_beat(2'b01, 2'd0, 4'b1111, 1'b0, lanes(32'h7FFFFFF0, 0, 0, 0), one0, 1'b1); exp_q.push_back(32'h7FFFFFF0);
    drive_beat(2'b10, 2'd0, 4'b1111, 1'b0, lanes(32'h100, 0, 0, 0), one0, 1'b1);      exp_q.push_back(32'h7FFFFFFF);
    drive_beat(2'b01, 2'd1, 4'b1111, 1'b0, lanes(32'h80000010, 0, 0, 0), one0, 1'b1); exp_q.push_back(32'h80000010);
    drive_beat(2'b10, 2'd1, 4'b1111, 1'b0, lanes(32'hFFFFFF00, 0, 0, 0), one0, 1'b1); exp_q.push_back(32'h80000000);
    drive_beat(2'b01, 2'd3, 4'b1111, 1'b1, lanes(32'hFFFFFFF0, 0, 0, 0), one0, 1'b1); exp_q.push_back(32'hFFFFFFF0);
    drive_beat(2'b10, 2'd3, 4'b1111, 1'b1, lanes(32'h100, 0, 0, 0), one0, 1'b1);      exp_q.push_back(32'hFFFFFFFF);
    drive_beat(2'b00, 2'd2, 4'b1111, 1'b0, lanes(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0), two1, 1'b1); exp_q.push_back(32'h7FFFFFFF);
    drive_beat(2'b00, 2'd2, 4'b1111, 1'b1, lanes(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0), two1, 1'b1); exp_q.push_back(32'hFFFFFFFF);
    drive_beat(2'b11, 2'd0, 4'b1111, 1'b0, '0, '0, 1'b1); exp_q.push_back(32'h7FFFFFFF);
    idle();
    wait_got(9, 1'b1, to);
    checks++; if (to) begin errors++; $display("FAIL sat_timeout got=%0d commits exp=9", got_s.size()); end
    while (exp_q.size() > 0 && got_s.size() > 0) begin
      logic [31:0] e;
      logic [NL*32-1:0] g;
      e = exp_q.pop_front(); g = got_s.pop_front();
      checks++; if (g !== {4{e}}) begin errors++; $display("FAIL sat_data got=%h exp=%h", g, {4{e}}); end
    end
    // the wrapping instance must overflow instead
    exp_q.delete();
    drive_beat(2'b01, 2'd3, 4'b1111, 1'b0, lanes(32'h7FFFFFF0, 0, 0, 0), one0, 1'b0); exp_q.push_back(32'h7FFFFFF0);
    drive_beat(2'b10, 2'd3, 4'b1111, 1'b0, lanes(32'h100, 0, 0, 0), one0, 1'b0);      exp_q.push_back(32'h800000F0);
    drive_beat(2'b00, 2'd2, 4'b1111, 1'b0, lanes(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0), two1, 1'b0); exp_q.push_back(32'hFFFFFFFE);
    idle();
    wait_got(3, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout got=%0d commits exp=3", got_d.size()); end
    while (exp_q.size() > 0 && got_d.size() > 0) begin
      logic [31:0] e;
      logic [NL*32-1:0] g;
      e = exp_q.pop_front(); g = got_d.pop_front();
      checks++; if (g !== {4{e}}) begin errors++; $display("FAIL wrap_data got=%h exp=%h", g, {4{e}}); end
    end
  endtask

  task automatic test_back_pressure();
    bit to, seen;
    got_d.delete(); exp_q.delete();
    d_cm_ready = 1'b0;
    for (int k = 1; k <= 6; k++) exp_q.push_back(32'(k * 11));
    fork
      begin
        for (int k = 1; k <= 6; k++)
          drive_beat(2'b00, 2'd0, 4'b0001, 1'b0, lanes(32'(k * 11), 0, 0, 0), lanes(1, 0, 0, 0), 1'b0);
        idle();
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge clk);
          seen = d_cm_valid;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_first_valid got=0 exp=1"); end
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", c, d_req_ready); end
          checks++; if (d_cm_valid !== 1'b1 || d_cm_data !== {4{32'd11}})
            begin errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h exp=%h", c, d_cm_valid, d_cm_data, {4{32'd11}}); end
        end
        @(posedge clk); #1;
        d_cm_ready = 1'b1;
      end
    join
    wait_got(6, 1'b0, to);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (to || got_d.size() != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got_d.size()); end
    while (exp_q.size() > 0 && got_d.size() > 0) begin
      logic [31:0] e;
      logic [NL*32-1:0] g;
      e = exp_q.pop_front(); g = got_d.pop_front();
      checks++; if (g !== {4{e}}) begin errors++; $display("FAIL bp_order got=%h exp=%h", g, {4{e}}); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    got_d.delete(); exp_q.delete();
    d_cm_ready = 1'b1;
    drive_beat(2'b01, 2'd0, 4'b1111, 1'b0, lanes(9, 0, 0, 0), lanes(1, 0, 0, 0), 1'b0);
    drive_beat(2'b10, 2'd0, 4'b1111, 1'b0, lanes(1, 0, 0, 0), lanes(1, 0, 0, 0), 1'b0);
    drive_beat(2'b00, 2'd1, 4'b1111, 1'b0, lanes(4, 0, 0, 0), lanes(1, 0, 0, 0), 1'b0);
    drive_beat(2'b00, 2'd1, 4'b1111, 1'b0, lanes(5, 0, 0, 0), lanes(1, 0, 0, 0), 1'b0);
    checks++; if (d_cm_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", d_cm_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (d_cm_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", d_cm_valid); end
    checks++; if (d_cm_data !== '0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", d_cm_data); end
    idle();
    @(posedge clk); #1;
    reset = 1'b1;
    got_d.delete();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL rst_discard got=%0d commits exp=0", got_d.size()); end
    drive_beat(2'b11, 2'd0, 4'b1111, 1'b0, '0, '0, 1'b0); exp_q.push_back(32'd0);
    drive_beat(2'b11, 2'd3, 4'b1111, 1'b0, '0, '0, 1'b0); exp_q.push_back(32'd0);
    idle();
    wait_got(2, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL rst_read_timeout got=%0d exp=2", got_d.size()); end
    while (exp_q.size() > 0 && got_d.size() > 0) begin
      logic [31:0] e;
      logic [NL*32-1:0] g;
      e = exp_q.pop_front(); g = got_d.pop_front();
      checks++; if (g !== {4{e}}) begin errors++; $display("FAIL rst_acc_cleared got=%h exp=%h", g, {4{e}}); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_dot_latency();
    test_tmask_sign();
    test_acc_sequence();
    test_saturate();
    test_back_pressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
